// File: rtl/event_pkg.sv
// Shared types and sizing constants for the event dispatcher slice.
package event_pkg;

   localparam int EVENT_W    = 16;
   localparam int MAX_EVENTS = 16;
   localparam int IDX_W      = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } dispatch_state_t;

endpackage

// File: rtl/event_dispatcher_if.sv
// CPU interrupt handshake: request/vector toward the core, ack/done back.
interface event_dispatcher_if;
   import event_pkg::*;

   logic               irq_req;
   logic [EVENT_W-1:0] vector_out;
   logic               irq_ack;
   logic               irq_done;

   modport master (output irq_req, output vector_out, input irq_ack, input irq_done);
   modport slave  (input irq_req, input vector_out, output irq_ack, output irq_done);

endinterface

// File: rtl/event_priority_encoder.sv
// Combinational highest-set-index encoder; the top index is the most urgent.
module event_priority_encoder
   import event_pkg::*;
#(
   parameter int NUM_INPUTS = 6
) (
   input  logic [NUM_INPUTS-1:0] candidates,
   output logic                  valid,
   output logic [IDX_W-1:0]      index
);

   // Scan upward so the last (highest) set bit determines the index.
   always_comb begin
      valid = |candidates;
      index = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_INPUTS; i++) begin
         index = candidates[i] ? IDX_W'(i) : index;
      end
   end

endmodule

// File: rtl/event_dispatcher.sv
// Latches event edges, gates them with a firmware mask and hands the most
// urgent one to the CPU through a req/ack/done handshake.
module event_dispatcher
   import event_pkg::*;
#(
   parameter int NUM_INPUTS = 6
) (
   input  logic                  sysclk,
   input  logic                  sysreset,
   input  logic [NUM_INPUTS-1:0] event_signals,
   input  logic                  mask_load,
   input  logic                  overrun_clear,
   input  logic [EVENT_W-1:0]    data_in,
   output logic [EVENT_W-1:0]    mask_out,
   output logic [EVENT_W-1:0]    pending_out,
   output logic [EVENT_W-1:0]    overrun_out,
   event_dispatcher_if.master    irq_bus
);

   dispatch_state_t       state_r;
   logic [NUM_INPUTS-1:0] ev_q_r;
   logic [NUM_INPUTS-1:0] pending_r;
   logic [NUM_INPUTS-1:0] overrun_r;
   logic [NUM_INPUTS-1:0] mask_r;
   logic [NUM_INPUTS-1:0] rise_s;
   logic [NUM_INPUTS-1:0] clear_s;
   logic [NUM_INPUTS-1:0] overrun_set_s;
   logic                  win_valid_s;
   logic [IDX_W-1:0]      win_index_s;

   event_priority_encoder #(
      .NUM_INPUTS (NUM_INPUTS)
   ) u_encoder (
      .candidates (pending_r & mask_r),
      .valid      (win_valid_s),
      .index      (win_index_s)
   );

   // Edge detection and the one-hot clear of the event being dispatched.
   always_comb begin
      rise_s  = event_signals & ~ev_q_r;
      clear_s = {NUM_INPUTS{1'b0}};
      if ((state_r == IDLE) && win_valid_s) begin
         clear_s = NUM_INPUTS'(1'b1) << win_index_s;
      end else begin
         clear_s = {NUM_INPUTS{1'b0}};
      end
      overrun_set_s = rise_s & pending_r & ~clear_s;
   end

   // Pending, overrun and mask registers; a new rise beats a clear on the same bit.
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         ev_q_r    <= {NUM_INPUTS{1'b0}};
         pending_r <= {NUM_INPUTS{1'b0}};
         overrun_r <= {NUM_INPUTS{1'b0}};
         mask_r    <= {NUM_INPUTS{1'b0}};
      end else begin
         ev_q_r    <= event_signals;
         pending_r <= (pending_r & ~clear_s) | rise_s;
         overrun_r <= (overrun_clear ? {NUM_INPUTS{1'b0}} : overrun_r) | overrun_set_s;
         if (mask_load) begin
            mask_r <= data_in[NUM_INPUTS-1:0];
         end else begin
            mask_r <= mask_r;
         end
      end
   end

   // Dispatch FSM with registered request and vector.
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         state_r            <= IDLE;
         irq_bus.irq_req    <= 1'b0;
         irq_bus.vector_out <= {EVENT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (win_valid_s) begin
                  state_r            <= REQ;
                  irq_bus.irq_req    <= 1'b1;
                  irq_bus.vector_out <= EVENT_W'(win_index_s);
               end else begin
                  irq_bus.irq_req    <= 1'b0;
               end
            end
            REQ: begin
               if (irq_bus.irq_ack) begin
                  state_r         <= SERVICE;
                  irq_bus.irq_req <= 1'b0;
               end else begin
                  irq_bus.irq_req <= 1'b1;
               end
            end
            SERVICE: begin
               irq_bus.irq_req <= 1'b0;
               if (irq_bus.irq_done) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= SERVICE;
               end
            end
            default: begin
               state_r         <= IDLE;
               irq_bus.irq_req <= 1'b0;
            end
         endcase
      end
   end

   assign mask_out    = EVENT_W'(mask_r);
   assign pending_out = EVENT_W'(pending_r);
   assign overrun_out = EVENT_W'(overrun_r);

endmodule

// File: tb/tb_event_dispatcher.sv
// Directed bench for event_dispatcher with a queue of expected dispatch vectors.
module tb_event_dispatcher;
   import event_pkg::*;

   logic        sysclk;
   logic        sysreset;
   logic [5:0]  event_signals;
   logic        mask_load;
   logic        overrun_clear;
   logic [15:0] data_in;
   logic [15:0] mask_out;
   logic [15:0] pending_out;
   logic [15:0] overrun_out;

   int compared;
   int mismatched;
   int exp_q[$];

   event_dispatcher_if irq_bus ();

   event_dispatcher #(
      .NUM_INPUTS (6)
   ) dut (
      .sysclk        (sysclk),
      .sysreset      (sysreset),
      .event_signals (event_signals),
      .mask_load     (mask_load),
      .overrun_clear (overrun_clear),
      .data_in       (data_in),
      .mask_out      (mask_out),
      .pending_out   (pending_out),
      .overrun_out   (overrun_out),
      .irq_bus       (irq_bus)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic load_mask(input logic [15:0] m);
      mask_load = 1'b1;
      data_in   = m;
      tick();
      mask_load = 1'b0;
      data_in   = 16'h0000;
   endtask

   // Wait a bounded number of cycles for a request, then compare against the scoreboard.
   task automatic wait_req(input string tag, input int budget);
      int exp_v;
      for (int i = 0; i < budget; i++) begin
         if (irq_bus.irq_req === 1'b1) break;
         tick();
      end
      check({tag, "_req"}, {15'h0000, irq_bus.irq_req}, 16'h0001);
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         check({tag, "_vec"}, irq_bus.vector_out, 16'(exp_v));
      end else begin
         check({tag, "_sb_empty"}, 16'h0001, 16'h0000);
      end
   endtask

   task automatic serve(input string tag);
      irq_bus.irq_ack = 1'b1;
      tick();
      irq_bus.irq_ack = 1'b0;
      check({tag, "_ackdrop"}, {15'h0000, irq_bus.irq_req}, 16'h0000);
      irq_bus.irq_done = 1'b1;
      tick();
      irq_bus.irq_done = 1'b0;
   endtask

   initial begin
      compared         = 0;
      mismatched       = 0;
      sysreset         = 1'b1;
      event_signals    = 6'h00;
      mask_load        = 1'b0;
      overrun_clear    = 1'b0;
      data_in          = 16'h0000;
      irq_bus.irq_ack  = 1'b0;
      irq_bus.irq_done = 1'b0;
      tick();
      tick();
      sysreset = 1'b0;
      check("rst_req", {15'h0000, irq_bus.irq_req}, 16'h0000);
      check("rst_vec", irq_bus.vector_out, 16'h0000);
      check("rst_mask", mask_out, 16'h0000);
      check("rst_pend", pending_out, 16'h0000);
      check("rst_ovr", overrun_out, 16'h0000);

      // 1: single event, exact 2-cycle latency
      load_mask(16'h003F);
      check("t1_mask", mask_out, 16'h003F);
      event_signals = 6'h04;
      exp_q.push_back(2);
      tick();
      event_signals = 6'h00;
      check("t1_pend", pending_out, 16'h0004);
      check("t1_noreq", {15'h0000, irq_bus.irq_req}, 16'h0000);
      tick();
      wait_req("t1", 0);
      check("t1_pend0", pending_out, 16'h0000);
      serve("t1");

      // 2: simultaneous events, priority order, idle gap
      event_signals = 6'h22;
      exp_q.push_back(5);
      exp_q.push_back(1);
      tick();
      event_signals = 6'h00;
      tick();
      wait_req("t2a", 0);
      check("t2_pend", pending_out, 16'h0002);
      serve("t2a");
      check("t2_gap", {15'h0000, irq_bus.irq_req}, 16'h0000);
      wait_req("t2b", 1);
      serve("t2b");

      // 3: masked event pends, dispatched once enabled
      load_mask(16'h0000);
      event_signals = 6'h08;
      tick();
      event_signals = 6'h00;
      tick();
      tick();
      check("t3_noreq", {15'h0000, irq_bus.irq_req}, 16'h0000);
      check("t3_pend", pending_out, 16'h0008);
      exp_q.push_back(3);
      load_mask(16'h0008);
      check("t3_lat", {15'h0000, irq_bus.irq_req}, 16'h0000);
      wait_req("t3", 1);
      serve("t3");

      // 4: overrun set, clear, and set-beats-clear
      load_mask(16'h0000);
      event_signals = 6'h01; tick();
      event_signals = 6'h00; tick();
      event_signals = 6'h01; tick();
      event_signals = 6'h00; tick();
      check("t4_ovr", overrun_out, 16'h0001);
      check("t4_pend", pending_out, 16'h0001);
      overrun_clear = 1'b1; tick(); overrun_clear = 1'b0;
      check("t4_clr", overrun_out, 16'h0000);
      event_signals = 6'h01;
      overrun_clear = 1'b1;
      tick();
      overrun_clear = 1'b0;
      event_signals = 6'h00;
      check("t4_setwins", overrun_out, 16'h0001);
      tick();

      // 5: reset in REQ, held event pends after release
      exp_q.push_back(0);
      load_mask(16'h003F);
      wait_req("t5a", 2);
      event_signals = 6'h10;
      sysreset = 1'b1;
      tick();
      sysreset = 1'b0;
      check("t5_req", {15'h0000, irq_bus.irq_req}, 16'h0000);
      check("t5_vec", irq_bus.vector_out, 16'h0000);
      check("t5_mask", mask_out, 16'h0000);
      check("t5_pend", pending_out, 16'h0000);
      check("t5_ovr", overrun_out, 16'h0000);
      tick();
      event_signals = 6'h00;
      check("t5_held", pending_out, 16'h0010);
      exp_q.push_back(4);
      load_mask(16'h003F);
      wait_req("t5b", 2);
      serve("t5b");

      // 6: same event re-arrives during its own service
      event_signals = 6'h04;
      exp_q.push_back(2);
      tick();
      event_signals = 6'h00;
      wait_req("t6a", 2);
      irq_bus.irq_ack = 1'b1;
      tick();
      irq_bus.irq_ack = 1'b0;
      event_signals = 6'h04;
      tick();
      event_signals = 6'h00;
      check("t6_pend", pending_out, 16'h0004);
      check("t6_ovr", overrun_out, 16'h0000);
      exp_q.push_back(2);
      irq_bus.irq_done = 1'b1;
      tick();
      irq_bus.irq_done = 1'b0;
      wait_req("t6b", 3);
      serve("t6b");

      check("sb_drained", 16'(exp_q.size()), 16'h0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
